// File: rtl/prog_loader.sv
// Boot loader: takes a framed byte stream, writes 16-bit words into instruction memory, then releases the core.
// Optional feature macro PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the CHECK state.
module prog_loader #(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_e;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_e S_AFTER_DATA = S_CHECK;
`else
  localparam state_e S_AFTER_DATA = S_DONE;
`endif

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         hi_q, hi_d;
  logic               imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic [15:0]        imem_wdata_q, imem_wdata_d;
  logic               rx_ready_q, rx_ready_d;
  logic               cpu_run_q, cpu_run_d;
  logic               load_done_q, load_done_d;
  logic               load_err_q, load_err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]         chk_q, chk_d;
`endif

  logic        accept_c;
  logic [15:0] n_full_c;
  logic        last_word_c;

  assign accept_c    = rx_valid && rx_ready_q;
  assign n_full_c    = {cnt_q[15:8], rx_data};
  assign last_word_c = (17'(idx_q) + 17'd1) == {1'b0, cnt_q};

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      hi_q         <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      rx_ready_q   <= 1'b1;
      cpu_run_q    <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      hi_q         <= hi_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      rx_ready_q   <= rx_ready_d;
      cpu_run_q    <= cpu_run_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  // Next state, counters and the one-cycle memory write
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    hi_d         = hi_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    chk_d        = chk_q;
`endif
    case (state_q)
      S_IDLE: if (accept_c && rx_data == HDR_BYTE) state_d = S_CNT_HI;
      S_CNT_HI: if (accept_c) begin
        cnt_d   = {rx_data, 8'h00};
        state_d = S_CNT_LO;
      end
      S_CNT_LO: if (accept_c) begin
        cnt_d = n_full_c;
        idx_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_d = '0;
`endif
        // Oversize counts are rejected here so the address can never wrap
        if (n_full_c == 16'd0)                 state_d = S_AFTER_DATA;
        else if ({1'b0, n_full_c} > MAX_N)     state_d = S_ERROR;
        else                                   state_d = S_DATA_HI;
      end
      S_DATA_HI: if (accept_c) begin
        hi_d    = rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_d   = chk_q ^ rx_data;
`endif
        state_d = S_DATA_LO;
      end
      S_DATA_LO: if (accept_c) begin
        imem_we_d    = 1'b1;
        imem_addr_d  = idx_q[ADDR_W-1:0];
        imem_wdata_d = {hi_q, rx_data};
        idx_d        = idx_q + IDX_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_d        = chk_q ^ rx_data;
`endif
        state_d      = last_word_c ? S_AFTER_DATA : S_DATA_HI;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: if (accept_c) state_d = (rx_data == chk_q) ? S_DONE : S_ERROR;
`endif
      S_DONE, S_ERROR: if (start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they register alongside it
  always_comb begin
    rx_ready_d  = 1'b1;
    cpu_run_d   = 1'b0;
    load_done_d = 1'b0;
    load_err_d  = 1'b0;
    case (state_d)
      S_DONE: begin
        rx_ready_d  = 1'b0;
        cpu_run_d   = 1'b1;
        load_done_d = 1'b1;
      end
      S_ERROR: begin
        rx_ready_d = 1'b0;
        load_err_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_run    = cpu_run_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream boot stage for the 16-bit RISC core.
- Receives a framed byte stream (from a UART receiver or test host) and writes 16-bit words into instruction memory.
- Holds the core stopped until the program has loaded and verified, then asserts cpu_run.
- Re-armable via start, so a new program can be loaded without a global reset.

Parameters:
- ADDR_W, 8: instruction-memory word-address width; capacity is 2^ADDR_W words.
- HDR_BYTE, 8'hA5: frame header byte.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_valid  input  1  rx_data holds a valid byte this cycle.
- rx_data  input  8  incoming byte.
- rx_ready  output  1  loader accepts a byte; transfer occurs when rx_valid && rx_ready.
- start  input  1  one-cycle pulse; re-arms the loader from DONE or ERROR.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  16  word to write.
- cpu_run  output  1  high releases the core; low holds it stopped.
- load_done  output  1  level; high in DONE.
- load_err  output  1  level; high in ERROR.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - All outputs 0 except rx_ready = 1.
  - Word counter, address, byte latch and checksum = 0.
  - Asserting reset mid-load abandons the frame. Words already written are not erased.
- Frame format: HDR_BYTE, CNT_HI, CNT_LO, then N words sent high byte first, then CHK. CHK is the XOR of every byte after CNT_LO. N is 16 bits.
- Byte acceptance: one byte per cycle when rx_valid && rx_ready. rx_ready = 1 in IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO and CHECK; rx_ready = 0 in DONE and ERROR.
- FSM transitions (all on an accepted byte unless noted):
  - IDLE: byte == HDR_BYTE -> CNT_HI. Any other byte is dropped and the state stays IDLE.
  - CNT_HI: latch N[15:8] -> CNT_LO.
  - CNT_LO: latch N[7:0].
    - N == 0 -> CHECK.
    - N > 2^ADDR_W -> ERROR.
    - Otherwise -> DATA_HI.
    - The address counter clears to 0.
  - DATA_HI: latch the high byte; XOR it into the checksum -> DATA_LO.
  - DATA_LO: XOR the byte into the checksum.
    - Next cycle: imem_we = 1 for exactly one cycle, imem_wdata = {hi, lo}, imem_addr = current word index.
    - The word index increments after the write.
    - Last word -> CHECK; otherwise -> DATA_HI.
    - Write latency: imem_we asserts 1 cycle after the low byte is accepted.
    - Back-to-back bytes are legal. The write pipeline never stalls rx_ready.
  - CHECK: byte == checksum -> DONE, else -> ERROR.
  - DONE: cpu_run = 1, load_done = 1. start -> IDLE, clearing cpu_run and load_done in the same edge.
  - ERROR: load_err = 1, cpu_run = 0. start -> IDLE, clearing load_err.
- start is ignored in every state other than DONE and ERROR.
- Wrap-around: addresses cannot wrap, because N > 2^ADDR_W is rejected before any write. N == 2^ADDR_W writes addresses 0 .. 2^ADDR_W-1.
- Simultaneous rx_valid and start in DONE or ERROR: start wins. The byte is not accepted because rx_ready = 0.
- imem_addr and imem_wdata hold their last value when imem_we = 0.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined: CHECK state present as described above; a checksum mismatch leads to ERROR.
- Undefined:
  - No checksum register and no CHECK state.
  - The last DATA_LO byte, or CNT_LO with N == 0, goes directly to DONE.
  - The frame has no CHK byte.
  - load_err is asserted only for oversize N.

Test Plan:
- Nominal load, ADDR_W = 8: A5 00 02 12 34 AB CD, CHK = 12^34^AB^CD = 0x40 -> imem_we at addr 0 with 0x1234, then addr 1 with 0xABCD; cpu_run = 1 and load_done = 1 one cycle after CHK is accepted.
- Bad checksum: same frame with CHK = 0x41 -> load_err = 1, cpu_run = 0, rx_ready = 0; a start pulse returns to IDLE with load_err = 0.
- Junk before header (00 FF 5A, then a valid frame with N = 1, word 0x0F0F, CHK 0x00) -> junk ignored; single write of 0x0F0F at addr 0; DONE.
- Oversize N = 0x0101 -> ERROR immediately after CNT_LO; no imem_we pulses.
- Zero-length frame: A5 00 00 00 -> DONE with no writes; second run without the macro: A5 00 00 -> DONE.
- Reset asserted after 3 data bytes of an N = 4 frame -> all outputs 0 and rx_ready = 1 asynchronously; a following full frame loads correctly from addr 0.
